// File: rtl/addsub_arbiter.sv
// Round-robin two-port front end for a single shared 8-bit adder/subtractor.
// One operation in flight at a time: accept (IDLE), compute (EXEC), hold result until taken (RESP).

module adder8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout
);
    logic [8:0] sum;

    assign sum  = 9'({1'b0, a}) + 9'({1'b0, b}) + 9'(cin);
    assign s    = sum[7:0];
    assign cout = sum[8];
endmodule

module addsub_arbiter #(
    parameter int unsigned RR_INIT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid0,
    input  logic       req_valid1,
    output logic       req_ready0,
    output logic       req_ready1,
    input  logic [7:0] req_a0,
    input  logic [7:0] req_a1,
    input  logic [7:0] req_b0,
    input  logic [7:0] req_b1,
    input  logic       req_sub0,
    input  logic       req_sub1,
    output logic       rsp_valid0,
    output logic       rsp_valid1,
    input  logic       rsp_ready0,
    input  logic       rsp_ready1,
    output logic [7:0] rsp_s,
    output logic       rsp_cout
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state_q, state_d;
    logic       prio_q, prio_d;
    logic       gnt_q;
    logic [7:0] a_q, b_q;
    logic       sub_q;
    logic [7:0] s_q;
    logic       cout_q;
    logic       rv0_q, rv0_d, rv1_q, rv1_d;

    logic       grant;
    logic       accept;
    logic       load_rsp;
    logic       ready0, ready1;

    logic [7:0] add_b;
    logic [7:0] add_s;
    logic       add_cout;

    // Subtract as a + ~b + 1; carry out of that sum is the inverse of the borrow.
    assign add_b = sub_q ? ~b_q : b_q;

    adder8 u_adder8 (
        .a    (a_q),
        .b    (add_b),
        .cin  (sub_q),
        .s    (add_s),
        .cout (add_cout)
    );

    // Next-state, grant and handshake decode.
    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        rv0_d    = rv0_q;
        rv1_d    = rv1_q;
        grant    = prio_q;
        accept   = 1'b0;
        load_rsp = 1'b0;
        ready0   = 1'b0;
        ready1   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid0 && req_valid1) grant = prio_q;
                else                          grant = req_valid1;
                if (req_valid0 || req_valid1) begin
                    ready0  = ~grant;
                    ready1  = grant;
                    accept  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                load_rsp = 1'b1;
                rv0_d    = ~gnt_q;
                rv1_d    = gnt_q;
                state_d  = RESP;
            end
            RESP: begin
                if (gnt_q ? rsp_ready1 : rsp_ready0) begin
                    rv0_d   = 1'b0;
                    rv1_d   = 1'b0;
                    prio_d  = ~gnt_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prio_q  <= 1'(RR_INIT);
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            rv0_q   <= rv0_d;
            rv1_q   <= rv1_d;
        end
    end

    // Operand capture on accept, result capture at the end of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q  <= 1'b0;
            a_q    <= 8'h00;
            b_q    <= 8'h00;
            sub_q  <= 1'b0;
            s_q    <= 8'h00;
            cout_q <= 1'b0;
        end else begin
            if (accept) begin
                gnt_q <= grant;
                a_q   <= grant ? req_a1   : req_a0;
                b_q   <= grant ? req_b1   : req_b0;
                sub_q <= grant ? req_sub1 : req_sub0;
            end
            if (load_rsp) begin
                s_q    <= add_s;
                cout_q <= add_cout ^ sub_q;
            end
        end
    end

    // Ready is combinational by interface contract; held low while reset is asserted.
    assign req_ready0 = rst_n & ready0;
    assign req_ready1 = rst_n & ready1;
    assign rsp_valid0 = rv0_q;
    assign rsp_valid1 = rv1_q;
    assign rsp_s      = s_q;
    assign rsp_cout   = cout_q;
endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Two-port arbiter and sequencer for one shared 8-bit adder/subtractor (`adder8`, instantiated inside this block). Two requesters each issue add or subtract operations over a valid/ready handshake. The block grants one requester at a time round-robin, registers its operands, drives the adder and holds the registered result until that requester accepts it. It sits between the operand-producing logic and the single arithmetic datapath, so the datapath needs no duplication.

## Interface
Parameters:
- `RR_INIT`, default 0: requester index that holds priority after reset (0 or 1).

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid0`, `req_valid1` input 1 each: requester has an operation pending.
- `req_ready0`, `req_ready1` output 1 each: operation accepted this cycle (handshake when valid && ready).
- `req_a0`, `req_a1` input 8 each: operand a.
- `req_b0`, `req_b1` input 8 each: operand b.
- `req_sub0`, `req_sub1` input 1 each: 1 = subtract (a − b), 0 = add (a + b).
- `rsp_valid0`, `rsp_valid1` output 1 each: result for that requester is valid; at most one is high in any cycle.
- `rsp_ready0`, `rsp_ready1` input 1 each: requester takes the result.
- `rsp_s` output 8: registered result, shared by both ports.
- `rsp_cout` output 1: registered carry or borrow flag, shared by both ports.

## Operation
- FSM states are IDLE, EXEC and RESP. A 1-bit priority pointer `prio` resets to `RR_INIT`.
- **IDLE**
  - If both valids are high, grant `prio`. If one is high, grant that one.
  - `req_readyN` is combinational: (state==IDLE) && grant==N. At most one ready is high per cycle.
  - On the handshake, capture a, b, sub and the grant index, then go to EXEC.
  - With no valid, stay in IDLE.
- **EXEC**
  - The captured operands drive `adder8`, with the captured sub bit on its `cin`.
  - The result is registered into `rsp_s` / `rsp_cout`. Go to RESP.
- **RESP**
  - Assert `rsp_valid` for the granted port. `rsp_s` / `rsp_cout` stay stable.
  - When the matching `rsp_ready` is high, deassert valid, set `prio` to the other port and return to IDLE.
  - The non-granted port's `rsp_ready` is ignored.
- Arithmetic rules:
  - Add: `rsp_s` = (a+b) mod 256, and `rsp_cout` = carry out of bit 7.
  - Subtract: `rsp_s` = (a−b) mod 256, and `rsp_cout` = 1 exactly when a < b (unsigned borrow, i.e. negative result).
- `prio` updates only on response completion, never on a grant. A requester that keeps valid high is therefore served at most every other operation when the other port is also requesting.
- Requester obligations: operands must stay stable while valid is high and ready is low. Valid may be withdrawn before ready without effect.

## Timing
- Reset values: `req_ready*`=0, `rsp_valid*`=0, `rsp_s`=0x00, `rsp_cout`=0, state=IDLE, `prio`=`RR_INIT`.
- Latency: handshake in cycle T → EXEC in T+1 → `rsp_validN` high from T+2.
- Earliest next accept is T+3, reached when `rsp_ready` is high at T+2. Peak throughput is one operation per 3 cycles.
- Backpressure: `rsp_validN` and the result hold indefinitely while `rsp_readyN` is low. No `req_ready*` is asserted during EXEC or RESP.
- A new request arriving in the same cycle the response is accepted is not granted until the following IDLE cycle.
- Reset asserted in any state, mid-operation included: outputs go to reset values asynchronously, and the in-flight operation is discarded and never reported.
- After `rst_n` deasserts, the first possible grant is the first rising edge with the block in IDLE.

## Test plan
- Port 0 subtracts a=0x05, b=0x03 → `req_ready0` in the accept cycle, `rsp_valid0` 2 cycles later, `rsp_s`=0x02, `rsp_cout`=0.
- Port 1 subtracts a=0x03, b=0x05 → `rsp_s`=0xFE, `rsp_cout`=1; `rsp_valid0` stays 0 throughout.
- Port 0 adds a=0xC8, b=0x64 → `rsp_s`=0x2C, `rsp_cout`=1. Port 0 adds 0x10+0x20 → `rsp_s`=0x30, `rsp_cout`=0.
- Both valids held high continuously, `RR_INIT`=0, rsp_ready always 1 → grants go 0,1,0,1. Each grant is 3 cycles apart, and results match each port's operands.
- Response backpressure: `rsp_ready0` held low 5 cycles with `req_valid1` high → `rsp_valid0`, `rsp_s` and `rsp_cout` stable for all 5 cycles, `req_ready1` stays 0. Port 1 is granted in the IDLE cycle after acceptance.
- `rst_n` pulsed low during EXEC → all outputs 0 immediately, no `rsp_valid` for the dropped operation. After release, a new request completes normally with priority back at `RR_INIT`.
